wd_rf_safety_sequencer: RTL
===========================

// Module: wd_rf_safety_sequencer
// PURPOSE
//   Sequences the RF output stage around watchdog_timer: arms/disarms the watchdog, forwards host heartbeats, ramps
//   carrier amplitude up/down, and latches a lockout after repeated watchdog trips. Sits between host control
//   registers and the AM modulator amplitude input; drives watchdog_timer enable/force_reset/heartbeat.
// PARAMETERS
//   AMP_WIDTH        8      amplitude bus width
//   RAMP_STEP_CYCLES 1000   clk cycles per 1-LSB amplitude step during ramps (>=1)
//   HOLDOFF_CYCLES   100000 clk cycles RF held at 0 after a trip before auto-retry (>=1)
//   MAX_RETRIES      3      trips tolerated before LOCKOUT (1..15)
// PORTS
//   clk             in   1          system clock
//   rstn            in   1          asynchronous active-low reset
//   arm_req         in   1          1-cycle pulse: start transmission
//   disarm_req      in   1          1-cycle pulse: orderly shutdown / clear lockout
//   host_heartbeat  in   1          1-cycle pulse from host software
//   amp_target      in   AMP_WIDTH  requested carrier amplitude
//   wd_warning      in   1          from watchdog_timer
//   wd_triggered    in   1          from watchdog_timer
//   wd_enable       out  1          to watchdog_timer enable
//   wd_force_reset  out  1          to watchdog_timer force_reset (1-cycle pulse)
//   wd_heartbeat    out  1          to watchdog_timer heartbeat
//   amp_out         out  AMP_WIDTH  amplitude to modulator
//   rf_enable       out  1          RF PA enable
//   fault_count     out  4          trips since last disarm/reset (saturating at 15)
//   locked_out      out  1          1 while in LOCKOUT
//   state           out  3          FSM state code
// BEHAVIOUR
//   Reset (async, rstn=0): state=IDLE, all outputs 0, step/holdoff counters 0. Everything else is registered on posedge clk.
//   States: IDLE=0 RAMP_UP=1 RUN=2 WARN=3 RAMP_DOWN=4 HOLDOFF=5 LOCKOUT=6; code 7 unreachable, recovers to IDLE.
//   IDLE: wd_enable=0, amp_out=0, rf_enable=0. arm_req -> RAMP_UP with a 1-cycle wd_force_reset pulse. Other inputs are ignored.
//   RAMP_UP: wd_enable=1, rf_enable=1. Every RAMP_STEP_CYCLES, amp_out+=1. amp_out==amp_target -> RUN.
//     If amp_target<amp_out, amp_out is clamped to amp_target in the next cycle. amp_target==0 -> RUN one cycle after entry.
//   RUN: amp_out follows amp_target with 1-cycle latency. wd_warning -> WARN.
//   WARN: same as RUN. wd_warning deasserted -> RUN.
//   Trip: wd_triggered in RAMP_UP/RUN/WARN -> RAMP_DOWN, and fault_count increments (saturating).
//   RAMP_DOWN: rf_enable stays 1 while amp_out!=0. amp_out decrements by 1 every RAMP_STEP_CYCLES.
//     When amp_out==0: rf_enable=0 and wd_enable=0, then:
//       - if disarming, go to IDLE and clear fault_count;
//       - else if fault_count>=MAX_RETRIES, go to LOCKOUT;
//       - otherwise go to HOLDOFF.
//   HOLDOFF: amp_out=0. After HOLDOFF_CYCLES -> RAMP_UP with a wd_force_reset pulse (auto-retry).
//   LOCKOUT: locked_out=1, amp_out=0. arm_req is ignored. disarm_req -> IDLE and clears fault_count.
//   disarm_req in RAMP_UP/RUN/WARN/HOLDOFF: sets the disarming flag and goes to RAMP_DOWN (from HOLDOFF: IDLE next cycle).
//     disarm_req in RAMP_DOWN sets the disarming flag; the ramp continues.
//     disarm_req and wd_triggered in the same cycle: disarm wins, fault_count is unchanged.
//   wd_heartbeat <= host_heartbeat while state is RAMP_UP/RUN/WARN, else 0 (1-cycle latency).
//     Heartbeats are never forwarded in the same cycle as wd_force_reset.
//   Step/holdoff counters reset to 0 on every state entry. Ramp arithmetic never wraps: amp_out stays in 0..2^AMP_WIDTH-1.
//   rstn asserted mid-ramp: amp_out drops to 0 immediately (async). This is the intended hard-kill path.
// TESTING  (bench params: RAMP_STEP_CYCLES=4, HOLDOFF_CYCLES=8, MAX_RETRIES=2)
//   arm_req, amp_target=3 -> force_reset pulse; amp_out 1,2,3 at ~4-cycle spacing; state=RUN; rf_enable=1.
//   RUN, amp_target 3->200 -> amp_out=200 one cycle later, no ramp.
//   RUN, wd_warning=1 then host_heartbeat -> state=WARN, wd_heartbeat pulse 1 cycle later, state=RUN when wd_warning drops.
//   RUN amp=3, wd_triggered -> fault_count=1, amp_out 2,1,0 (4 cycles/step), rf_enable=0, HOLDOFF 8 cycles, RAMP_UP with force_reset.
//   Second trip -> fault_count=2, ramp to 0, LOCKOUT, locked_out=1; arm_req ignored; disarm_req -> IDLE, fault_count=0.
//   disarm_req and wd_triggered same cycle in RUN -> RAMP_DOWN, fault_count unchanged, ends in IDLE; rstn low mid-ramp -> all outputs 0.

Source files
------------

// File: rtl/wd_rf_safety_sequencer.sv
// RF output-stage safety sequencer: arms the watchdog, ramps carrier amplitude,
// retries after watchdog trips and latches a lockout after repeated trips.
`timescale 1ns/1ps
module wd_rf_safety_sequencer #(
  parameter int unsigned AMP_WIDTH        = 8,
  parameter int unsigned RAMP_STEP_CYCLES = 1000,
  parameter int unsigned HOLDOFF_CYCLES   = 100000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arm_req,
  input  logic                 disarm_req,
  input  logic                 host_heartbeat,
  input  logic [AMP_WIDTH-1:0] amp_target,
  input  logic                 wd_warning,
  input  logic                 wd_triggered,
  output logic                 wd_enable,
  output logic                 wd_force_reset,
  output logic                 wd_heartbeat,
  output logic [AMP_WIDTH-1:0] amp_out,
  output logic                 rf_enable,
  output logic [3:0]           fault_count,
  output logic                 locked_out,
  output logic [2:0]           state
);

  localparam int unsigned CNT_MAX = (RAMP_STEP_CYCLES > HOLDOFF_CYCLES) ? RAMP_STEP_CYCLES
                                                                        : HOLDOFF_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_WARN      = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_HOLDOFF   = 3'd5,
    S_LOCKOUT   = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [AMP_WIDTH-1:0] r_amp;
  logic [AMP_WIDTH-1:0] w_amp_nxt;
  logic [3:0]           r_fault;
  logic [3:0]           w_fault_nxt;
  logic                 r_disarming;
  logic                 w_disarming_nxt;
  logic                 w_step_done;

  logic r_wd_enable, w_wd_enable_nxt;
  logic r_force_reset, w_force_reset_nxt;
  logic r_heartbeat, w_heartbeat_nxt;
  logic r_rf_enable, w_rf_enable_nxt;
  logic r_locked, w_locked_nxt;

  assign w_step_done = (r_cnt == STEP_LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic together with amplitude, fault counter and step/holdoff counter
  always_comb begin
    w_state_nxt     = r_state;
    w_amp_nxt       = r_amp;
    w_fault_nxt     = r_fault;
    w_disarming_nxt = r_disarming;
    w_cnt_nxt       = '0;
    case (r_state)
      S_IDLE: begin
        w_amp_nxt       = '0;
        w_disarming_nxt = 1'b0;
        if (arm_req) w_state_nxt = S_RAMP_UP;
      end
      S_RAMP_UP, S_RUN, S_WARN: begin
        if (disarm_req) begin
          // Disarm outranks a simultaneous trip and does not count it
          w_disarming_nxt = 1'b1;
          w_state_nxt     = S_RAMP_DOWN;
        end else if (wd_triggered) begin
          w_state_nxt = S_RAMP_DOWN;
          w_fault_nxt = (r_fault == 4'hF) ? r_fault : r_fault + 4'd1;
        end else if (r_state == S_RAMP_UP) begin
          if (amp_target < r_amp) begin
            w_amp_nxt = amp_target;
          end else if (amp_target == r_amp) begin
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = w_step_done ? '0 : r_cnt + CNT_W'(1);
            if (w_step_done) w_amp_nxt = r_amp + AMP_WIDTH'(1);
          end
        end else begin
          w_amp_nxt = amp_target;
          if ((r_state == S_RUN) && wd_warning)       w_state_nxt = S_WARN;
          else if ((r_state == S_WARN) && !wd_warning) w_state_nxt = S_RUN;
        end
      end
      S_RAMP_DOWN: begin
        if (disarm_req) w_disarming_nxt = 1'b1;
        if (r_amp != '0) begin
          w_cnt_nxt = w_step_done ? '0 : r_cnt + CNT_W'(1);
          if (w_step_done) w_amp_nxt = r_amp - AMP_WIDTH'(1);
        end else if (r_disarming || disarm_req) begin
          w_state_nxt     = S_IDLE;
          w_fault_nxt     = 4'd0;
          w_disarming_nxt = 1'b0;
        end else if (r_fault >= RETRY_LIM) begin
          w_state_nxt = S_LOCKOUT;
        end else begin
          w_state_nxt = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        w_amp_nxt = '0;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (disarm_req) begin
          w_state_nxt     = S_IDLE;
          w_fault_nxt     = 4'd0;
          w_disarming_nxt = 1'b0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RAMP_UP;
        end
      end
      S_LOCKOUT: begin
        w_amp_nxt = '0;
        if (disarm_req) begin
          w_state_nxt     = S_IDLE;
          w_fault_nxt     = 4'd0;
          w_disarming_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_amp_nxt       = '0;
        w_fault_nxt     = 4'd0;
        w_disarming_nxt = 1'b0;
      end
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Next values of the registered control outputs, derived from the upcoming state
  always_comb begin
    w_wd_enable_nxt   = 1'b0;
    w_rf_enable_nxt   = 1'b0;
    w_force_reset_nxt = ((r_state == S_IDLE) || (r_state == S_HOLDOFF)) &&
                        (w_state_nxt == S_RAMP_UP);
    w_locked_nxt      = (w_state_nxt == S_LOCKOUT);
    w_heartbeat_nxt   = host_heartbeat && !w_force_reset_nxt &&
                        ((r_state == S_RAMP_UP) || (r_state == S_RUN) || (r_state == S_WARN));
    case (w_state_nxt)
      S_RAMP_UP, S_RUN, S_WARN: begin
        w_wd_enable_nxt = 1'b1;
        w_rf_enable_nxt = 1'b1;
      end
      S_RAMP_DOWN: begin
        w_wd_enable_nxt = (w_amp_nxt != '0);
        w_rf_enable_nxt = (w_amp_nxt != '0);
      end
      default: begin
        w_wd_enable_nxt = 1'b0;
        w_rf_enable_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears amplitude immediately (hard kill)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt         <= '0;
      r_amp         <= '0;
      r_fault       <= 4'd0;
      r_disarming   <= 1'b0;
      r_wd_enable   <= 1'b0;
      r_force_reset <= 1'b0;
      r_heartbeat   <= 1'b0;
      r_rf_enable   <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_amp         <= w_amp_nxt;
      r_fault       <= w_fault_nxt;
      r_disarming   <= w_disarming_nxt;
      r_wd_enable   <= w_wd_enable_nxt;
      r_force_reset <= w_force_reset_nxt;
      r_heartbeat   <= w_heartbeat_nxt;
      r_rf_enable   <= w_rf_enable_nxt;
      r_locked      <= w_locked_nxt;
    end
  end

  assign wd_enable      = r_wd_enable;
  assign wd_force_reset = r_force_reset;
  assign wd_heartbeat   = r_heartbeat;
  assign amp_out        = r_amp;
  assign rf_enable      = r_rf_enable;
  assign fault_count    = r_fault;
  assign locked_out     = r_locked;
  assign state          = r_state;

endmodule
